// File: rtl/rd_fifo_interface_pkg.sv
// Shared constants and helpers for the read-side FIFO interface.
// The state encodings match the write-side unpacker so both interfaces
// decode the same way in waveforms and debug tooling.
package rd_fifo_interface_pkg;

    // Two-state handshake: gather bytes, then hand one word to the Read FIFO.
    typedef enum logic {
        STATE_FILL  = 1'b0,
        STATE_WRITE = 1'b1
    } state_t;

    // Bits needed to index `value` distinct items; never narrower than 1 bit.
    function automatic int log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    // Integer division rounded up.
    function automatic int ceil_division(input int numerator, input int denominator);
        return (numerator + denominator - 1) / denominator;
    endfunction

endpackage

// File: rtl/rd_fifo_interface.sv
// Read-path byte packer: gathers bytes from the flash controller MSB-first
// into Read FIFO words, pushes each complete (or flushed, padded) word, and
// counts the words pushed.
module rd_fifo_interface
    import rd_fifo_interface_pkg::*;
#(
    parameter int         RD_FIFO_DATA_WIDTH = 128,
    parameter logic [7:0] PAD_BYTE           = 8'hFF,
    parameter int         COUNT_WIDTH        = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_ctrl_data,
    input  logic                          i_ctrl_we,
    input  logic                          i_ctrl_flush,
    output logic                          o_ctrl_full,
    output logic [RD_FIFO_DATA_WIDTH-1:0] o_rd_fifo_data,
    output logic                          o_rd_fifo_we,
    input  logic                          i_rd_fifo_full,
    output logic [COUNT_WIDTH-1:0]        o_word_count
);

    localparam int NUM_OF_BYTES = ceil_division(RD_FIFO_DATA_WIDTH, 8);
    localparam int INDEX_WIDTH  = log2(NUM_OF_BYTES);
    localparam logic [INDEX_WIDTH-1:0]        LAST_INDEX = INDEX_WIDTH'(NUM_OF_BYTES - 1);
    localparam logic [RD_FIFO_DATA_WIDTH-1:0] PAD_WORD   = {NUM_OF_BYTES{PAD_BYTE}};

    state_t                          state_reg,    state_next;
    logic [INDEX_WIDTH-1:0]          index_reg,    index_next;
    logic [RD_FIFO_DATA_WIDTH-1:0]   assembly_reg, assembly_next;
    logic [RD_FIFO_DATA_WIDTH-1:0]   data_reg,     data_next;
    logic [COUNT_WIDTH-1:0]          count_reg,    count_next;
    logic                            ctrl_full;
    logic                            fifo_we;
    logic                            byte_accept;
    logic                            word_done;
    int                              lane_lsb;

    // Next-state, lane write and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next    = state_reg;
        index_next    = index_reg;
        assembly_next = assembly_reg;
        data_next     = data_reg;
        count_next    = count_reg;
        ctrl_full     = 1'b0;
        fifo_we       = 1'b0;
        byte_accept   = 1'b0;
        word_done     = 1'b0;
        // Byte k of a word lands in the k-th lane from the top.
        lane_lsb      = (NUM_OF_BYTES - 1 - int'(index_reg)) * 8;

        case (state_reg)
            STATE_FILL: begin
                byte_accept = i_ctrl_we;
                if (byte_accept) begin
                    assembly_next[lane_lsb +: 8] = i_ctrl_data;
                    index_next                   = index_reg + INDEX_WIDTH'(1);
                end
                // A flush on the last byte is the same event as a full word,
                // so exactly one push results. A flush with nothing gathered
                // is dropped.
                word_done = (byte_accept && (index_reg == LAST_INDEX)) ||
                            (i_ctrl_flush && (byte_accept || (index_reg != '0)));
                if (word_done) begin
                    data_next  = assembly_next;
                    index_next = '0;
                    state_next = STATE_WRITE;
                end
            end

            STATE_WRITE: begin
                // Bytes and flushes are refused while the word is pending.
                ctrl_full = 1'b1;
                fifo_we   = !i_rd_fifo_full;
                if (fifo_we) begin
                    count_next    = count_reg + COUNT_WIDTH'(1);
                    assembly_next = PAD_WORD;
                    state_next    = STATE_FILL;
                end
            end

            default: begin
                state_next = STATE_FILL;
            end
        endcase
    end

    // State, assembly and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= STATE_FILL;
            index_reg    <= '0;
            assembly_reg <= PAD_WORD;
            data_reg     <= '0;
            count_reg    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_reg    <= state_next;
            index_reg    <= index_next;
            assembly_reg <= assembly_next;
            data_reg     <= data_next;
            count_reg    <= count_next;
        end
    end

    assign o_ctrl_full    = ctrl_full;
    assign o_rd_fifo_we   = fifo_we;
    assign o_rd_fifo_data = data_reg;
    assign o_word_count   = count_reg;

endmodule
